// File: rtl/clock_sync_host_if.sv
// PC104 I/O-cycle bus between the clock-sync host (master) and the peripheral (slave).
interface clock_sync_host_if;
  logic [9:0] address;
  logic       aen;
  logic       write_n;
  logic       read_n;
  logic [7:0] data_out;
  logic       data_oe;
  logic [7:0] data_in;

  modport master (
    output address, aen, write_n, read_n, data_out, data_oe,
    input  data_in
  );

  modport slave (
    input  address, aen, write_n, read_n, data_out, data_oe,
    output data_in
  );
endinterface

// File: rtl/clock_sync_host.sv
// PC104 host that runs GET/SET command sequences against the clock-sync peripheral,
// with IRQ-triggered GETs. All outputs are registered from the next-state values.
module clock_sync_host #(
  parameter logic [9:0] ADDRESS    = 10'h233,
  parameter int         SETUP_CYC  = 2,
  parameter int         STROBE_CYC = 4,
  parameter int         HOLD_CYC   = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start_get,
  input  logic               start_set,
  input  logic [4:0]         set_hr,
  input  logic [5:0]         set_min,
  input  logic [5:0]         set_sec,
  input  logic               irq_in,
  output logic               busy,
  output logic               get_valid,
  output logic               set_done,
  output logic [4:0]         get_hr,
  output logic [5:0]         get_min,
  output logic [5:0]         get_sec,
  clock_sync_host_if.master  bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ARM    = 3'd1;
  localparam logic [2:0] S_SETUP  = 3'd2;
  localparam logic [2:0] S_STROBE = 3'd3;
  localparam logic [2:0] S_HOLD   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam logic [7:0] SETUP_LAST  = 8'(SETUP_CYC - 1);
  localparam logic [7:0] STROBE_LAST = 8'(STROBE_CYC - 1);
  localparam logic [7:0] HOLD_LAST   = 8'(HOLD_CYC - 1);

  // GET: even steps write a select byte, odd steps read; SET: every step writes.
  function automatic logic [7:0] cmd_byte(input logic is_set, input logic [2:0] step,
                                          input logic [3:0] hr, input logic [4:0] mn,
                                          input logic [4:0] sc);
    logic [7:0] b;
    b = 8'h00;
    if (is_set) begin
      case (step[1:0])
        2'd0:    b = {4'b1000, hr};
        2'd1:    b = {3'b101, mn};
        2'd2:    b = {3'b110, sc};
        default: b = 8'hE0;
      endcase
    end else begin
      b = {1'b0, step[2:1], 5'b00000};
    end
    return b;
  endfunction

  logic [2:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] step_q, step_d;
  logic       is_set_q, is_set_d, irq_pend_q, irq_pend_d;
  logic [3:0] hr_q, hr_d, rd_hr_q, rd_hr_d;
  logic [4:0] min_q, min_d, sec_q, sec_d, rd_min_q, rd_min_d, rd_sec_q, rd_sec_d;
  logic       busy_q, get_valid_q, set_done_q;
  logic [4:0] get_hr_q;
  logic [5:0] get_min_q, get_sec_q;
  logic [9:0] address_q, address_d;
  logic       aen_q, aen_d, write_n_q, write_n_d, read_n_q, read_n_d, data_oe_q, data_oe_d;
  logic [7:0] data_out_q, data_out_d;
  logic       rd_cycle_s, wr_next_s, in_cycle_s, done_next_s;
  logic [2:0] last_step_s;
  logic       unused_s;

  assign unused_s    = ^{set_hr[4], set_min[5], set_sec[5], bus.data_in[7:5]};
  assign rd_cycle_s  = ~is_set_q & step_q[0];
  assign last_step_s = is_set_q ? 3'd3 : 3'd5;

  // Sequencer: request arbitration, phase counting, read capture.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    step_d     = step_q;
    is_set_d   = is_set_q;
    irq_pend_d = irq_pend_q | irq_in;
    hr_d       = hr_q;
    min_d      = min_q;
    sec_d      = sec_q;
    rd_hr_d    = rd_hr_q;
    rd_min_d   = rd_min_q;
    rd_sec_d   = rd_sec_q;
    case (state_q)
      S_IDLE: begin
        if (start_set) begin
          state_d  = S_ARM;
          is_set_d = 1'b1;
          step_d   = 3'd0;
          hr_d     = set_hr[3:0];
          min_d    = set_min[4:0];
          sec_d    = set_sec[4:0];
        end else if (start_get || irq_pend_q || irq_in) begin
          state_d    = S_ARM;
          is_set_d   = 1'b0;
          step_d     = 3'd0;
          irq_pend_d = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ARM: begin
        state_d = S_SETUP;
        cnt_d   = 8'd0;
      end
      S_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = S_STROBE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_STROBE: begin
        if (cnt_q == STROBE_LAST) begin
          state_d = S_HOLD;
          cnt_d   = 8'd0;
          if (rd_cycle_s) begin
            case (step_q[2:1])
              2'd0:    rd_hr_d  = bus.data_in[3:0];
              2'd1:    rd_min_d = bus.data_in[4:0];
              default: rd_sec_d = bus.data_in[4:0];
            endcase
          end else begin
            rd_hr_d = rd_hr_q;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d = 8'd0;
          if (step_q == last_step_s) begin
            state_d = S_DONE;
          end else begin
            state_d = S_SETUP;
            step_d  = step_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Bus pins for the coming clock; aen/data_oe stay asserted across back-to-back cycles.
  always_comb begin
    in_cycle_s  = (state_d == S_SETUP) || (state_d == S_STROBE) || (state_d == S_HOLD);
    wr_next_s   = is_set_d | ~step_d[0];
    done_next_s = (state_d == S_DONE);
    address_d   = in_cycle_s ? ADDRESS : 10'h000;
    aen_d       = ~in_cycle_s;
    write_n_d   = ~((state_d == S_STROBE) & wr_next_s);
    read_n_d    = ~((state_d == S_STROBE) & ~wr_next_s);
    data_oe_d   = in_cycle_s & wr_next_s;
    if (in_cycle_s && wr_next_s) begin
      data_out_d = cmd_byte(is_set_d, step_d, hr_d, min_d, sec_d);
    end else begin
      data_out_d = 8'h00;
    end
  end

  // State and registered outputs, synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      step_q      <= 3'd0;
      is_set_q    <= 1'b0;
      irq_pend_q  <= 1'b0;
      hr_q        <= 4'd0;
      min_q       <= 5'd0;
      sec_q       <= 5'd0;
      rd_hr_q     <= 4'd0;
      rd_min_q    <= 5'd0;
      rd_sec_q    <= 5'd0;
      busy_q      <= 1'b0;
      get_valid_q <= 1'b0;
      set_done_q  <= 1'b0;
      get_hr_q    <= 5'd0;
      get_min_q   <= 6'd0;
      get_sec_q   <= 6'd0;
      address_q   <= 10'h000;
      aen_q       <= 1'b1;
      write_n_q   <= 1'b1;
      read_n_q    <= 1'b1;
      data_oe_q   <= 1'b0;
      data_out_q  <= 8'h00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      step_q      <= step_d;
      is_set_q    <= is_set_d;
      irq_pend_q  <= irq_pend_d;
      hr_q        <= hr_d;
      min_q       <= min_d;
      sec_q       <= sec_d;
      rd_hr_q     <= rd_hr_d;
      rd_min_q    <= rd_min_d;
      rd_sec_q    <= rd_sec_d;
      busy_q      <= (state_d != S_IDLE);
      get_valid_q <= done_next_s & ~is_set_q;
      set_done_q  <= done_next_s & is_set_q;
      if (done_next_s && !is_set_q) begin
        get_hr_q  <= {1'b0, rd_hr_q};
        get_min_q <= {1'b0, rd_min_q};
        get_sec_q <= {1'b0, rd_sec_q};
      end else begin
        get_hr_q  <= get_hr_q;
      end
      address_q   <= address_d;
      aen_q       <= aen_d;
      write_n_q   <= write_n_d;
      read_n_q    <= read_n_d;
      data_oe_q   <= data_oe_d;
      data_out_q  <= data_out_d;
    end
  end

  assign busy         = busy_q;
  assign get_valid    = get_valid_q;
  assign set_done     = set_done_q;
  assign get_hr       = get_hr_q;
  assign get_min      = get_min_q;
  assign get_sec      = get_sec_q;
  assign bus.address  = address_q;
  assign bus.aen      = aen_q;
  assign bus.write_n  = write_n_q;
  assign bus.read_n   = read_n_q;
  assign bus.data_oe  = data_oe_q;
  assign bus.data_out = data_out_q;

endmodule

// File: doc/clock_sync_host.md
Name: clock_sync_host

Overview:
- PC104 I/O-cycle initiator that drives the clock-sync peripheral at the far end of the bus.
- Runs two transactions:
  - GET: reads hours, minutes and seconds from the peripheral.
  - SET: writes hours, minutes and seconds, then issues DONE.
- Sits on the host/bridge side of the bus. It also services the peripheral's sync-request interrupt by running a GET automatically.

Parameters:
- ADDRESS, 10'h233, I/O address driven during every bus cycle.
- SETUP_CYC, 2, clocks that address/aen/write-data are valid before the strobe falls (≥1).
- STROBE_CYC, 4, clocks the strobe is held low (≥1).
- HOLD_CYC, 2, clocks that address/aen/write-data are held after the strobe rises (≥1).

Ports:
- clock  in  1  system clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start_get  in  1  one-cycle request to run a GET.
- start_set  in  1  one-cycle request to run a SET.
- set_hr  in  5  hours to write.
- set_min  in  6  minutes to write.
- set_sec  in  6  seconds to write.
- irq_in  in  1  one-cycle sync-request pulse from the peripheral.
- busy  out  1  high while a transaction is in progress.
- get_valid  out  1  one-cycle pulse: get_hr/get_min/get_sec have been updated.
- set_done  out  1  one-cycle pulse: SET sequence complete.
- get_hr  out  5  last hours value read.
- get_min  out  6  last minutes value read.
- get_sec  out  6  last seconds value read.
- address  out  10  bus address.
- aen  out  1  address enable, active low = I/O cycle.
- write_n  out  1  I/O write strobe, active low.
- read_n  out  1  I/O read strobe, active low.
- data_out  out  8  write data.
- data_oe  out  1  write-data output enable.
- data_in  in  8  read data from the bus.

Behaviour:
- Reset values:
  - aen=1, write_n=1, read_n=1, data_oe=0, data_out=0, address=0.
  - busy=0, get_valid=0, set_done=0, get_hr/min/sec=0.
  - IRQ-pending flag cleared, FSM in IDLE.
- Command byte encoding:
  - bit7 = mode (1 set, 0 pre-read select); bits6:5 = choice (00 hr, 01 min, 10 sec, 11 done).
  - Value field: hr in [3:0], min/sec in [4:0]; all other bits 0.
  - set_hr[4] and set_min[5]/set_sec[5] are not transmitted.
- Read byte decoding:
  - get_hr = {1'b0, data_in[3:0]}.
  - get_min/get_sec = {1'b0, data_in[4:0]}.
- Bus cycle FSM: IDLE -> SETUP -> STROBE -> HOLD -> (next cycle SETUP, or IDLE).
  - SETUP (SETUP_CYC clocks): address=ADDRESS, aen=0; write cycles also drive data_oe=1 and data_out=command.
  - STROBE (STROBE_CYC clocks): write_n=0 or read_n=0. For reads, data_in is captured on the last STROBE clock.
  - HOLD (HOLD_CYC clocks): strobes=1; address, aen and data held.
  - Leaving HOLD: aen=1 and data_oe=0 unless the next bus cycle follows directly.
  - Only one strobe is ever low at a time; they are never low simultaneously.
- GET sequence, 6 bus cycles: W{0,00,00000}, R, W{0,01,00000}, R, W{0,10,00000}, R.
  - All three captured fields update together in the clock after the final HOLD, with get_valid=1.
- SET sequence, 4 bus cycles: W{1,00,0,hr[3:0]}, W{1,01,min[4:0]}, W{1,10,sec[4:0]}, W{1,11,00000}.
  - set_done=1 in the clock after the final HOLD.
- set_hr/set_min/set_sec are registered when start_set is accepted; later input changes do not affect the running SET.
- Latency with P = SETUP_CYC+STROBE_CYC+HOLD_CYC:
  - GET: get_valid rises 6P+1 clocks after start is sampled (49 at defaults).
  - SET: set_done rises 4P+1 clocks after start is sampled (33 at defaults).
  - busy=1 from the clock after acceptance through the done pulse, inclusive.
- Arbitration in IDLE when requests coincide: start_set > start_get > pending IRQ.
- start_get/start_set while busy are ignored.
- irq_in while busy sets the one-deep pending flag; repeated IRQs merge. The pending GET starts on the first IDLE clock after the done pulse.
- irq_in in IDLE with no start request starts a GET immediately.
- Reset mid-transaction: all outputs return to reset values on that edge.
  - Releasing write_n produces a rising edge that the peripheral may latch. This is accepted behaviour; software reissues SET.

Test Plan:
- start_get with the peripheral model returning hr=9, min=27, sec=5:
  - Required: three select writes 0x00/0x20/0x40 interleaved with three reads.
  - get_hr=9, get_min=27, get_sec=5, get_valid pulse at clock 49.
- start_set with hr=12, min=34, sec=56:
  - Required: write bytes 0x8C, 0xA2, 0xD8, 0xE0 in that order.
  - Upper bits dropped; set_done at clock 33.
- Timing check at defaults:
  - aen=0 and address=0x233 exactly 2 clocks before each strobe falls.
  - Strobe low exactly 4 clocks; hold 2 clocks after it rises.
  - data_oe=0 throughout every read cycle.
- start_set and start_get in the same clock: SET runs and the GET request is dropped. Then irq_in pulsed twice during the SET: exactly one GET follows set_done.
- Assert reset during the second STROBE clock of a write: on the next clock write_n=1, read_n=1, aen=1, data_oe=0, busy=0, and no done pulse occurs.
- After reset, a start_get completes normally and returns the peripheral's values.
